sr_flop_bank: RTL and testbench
===============================

// Module: sr_flop_bank
// PURPOSE
//  Parametrised bank of N clocked SR storage cells with a shared enable; successor to our single-bit SR latch.
//  Adds a selectable policy for S=R=1, a per-channel input glitch filter, and sticky rising-edge flags.
//  Used for status/alarm capture: q feeds control logic; flags and any_flag feed the interrupt logic.
// PARAMETERS
//  N          8    number of channels (1..32)
//  FILTER     0    cycles {s,r} must stay stable before acting (0 = no filter, 0..255)
//  MODE       1    S=R=1 policy: 0 HOLD, 1 SET_DOM, 2 RST_DOM, 3 TOGGLE
//  RESET_VAL  0    q value of every channel after reset
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  en         in   1   update enable, shared by all channels, not filtered
//  s          in   N   per-channel set request
//  r          in   N   per-channel reset request
//  clr_flags  in   N   per-channel clear of rise_flag (one-cycle pulse)
//  q          out  N   stored value
//  qn         out  N   always ~q (combinational from q register)
//  rise_flag  out  N   sticky: q went 0->1
//  conflict   out  N   one-cycle pulse: qualified S=R=1 applied while en=1
//  any_flag   out  1   OR of rise_flag
// BEHAVIOUR
//  Reset (rst_n=0, async): q=RESET_VAL, qn=~RESET_VAL, rise_flag=0, conflict=0, any_flag=0.
//  Reset also clears filter counters and stored previous pairs (to 00). Mid-operation reset aborts a pending qualification.
//  Filter, per channel: reg prev_i holds last {s,r}; cnt_i is 8 bits.
//   - {s,r} != prev_i: prev_i <= {s,r}, cnt_i <= 0.
//   - otherwise, if cnt_i < FILTER: cnt_i++. cnt_i saturates at FILTER.
//   - qualified pair = {s,r} when FILTER=0; otherwise prev_i when cnt_i==FILTER.
//   - Latency: q changes FILTER+1 rising edges after {s,r} settles (1 edge when FILTER=0).
//  Filter runs regardless of en. A pair stays qualified while stable, so it re-applies every cycle.
//  Update, per channel, at clk edge when en=1 and pair qualified:
//   00 hold | 10 q<=1 | 01 q<=0 | 11 per MODE: HOLD keep, SET_DOM 1, RST_DOM 0, TOGGLE ~q (every cycle).
//  en=0, or pair not qualified: q holds; conflict<=0.
//  conflict_i <= 1 for exactly the cycles where qualified 11 is applied with en=1, else 0.
//  rise_flag_i: set when the registered q_i goes 0->1 (next cycle); cleared by clr_flags_i.
//   Set wins over a simultaneous clear. A reset-value of 1 does not set the flag.
//  any_flag: combinational OR of the rise_flag register outputs.
//  Channels are fully independent; there is no cross-channel priority.
// STRUCTURE
//  Package sr_bank_pkg: MODE_HOLD=0, MODE_SET_DOM=1, MODE_RST_DOM=2, MODE_TOGGLE=3; filter counter width CNT_W=8.
//  Sub-module sr_bank_chan: one channel (filter, q register, conflict, rise_flag), instantiated N times by a generate loop.
//  Top-level: generate loop plus the any_flag reduction. Elaboration check: MODE<=3 and FILTER<=255.
// TESTING
//  1 N=4,FILTER=0,MODE=1: reset then en=1,s=0001 -> q=0001 after 1 edge; rise_flag=0001, any_flag=1.
//  2 s=r=0001, en=1: MODE=1 -> q0=1; MODE=2 -> q0=0; MODE=0 -> hold; MODE=3 -> q0 toggles each edge.
//    All modes: conflict0=1 while applied.
//  3 FILTER=3: 2-cycle s pulse -> q unchanged; s held 5 cycles -> q0=1 exactly 4 edges after s rises.
//  4 en=0 with s=1111 for 10 cycles -> q holds 0000. Raise en -> q=1111 on next edge (FILTER=0).
//  5 clr_flags=0001 in the same cycle as a new q0 0->1 -> rise_flag0 stays 1; later clear alone -> 0, any_flag=0.
//  6 rst_n low mid-filter (FILTER=3, cnt=2) and asynchronously between edges -> all outputs at reset values immediately.
//    After release, a stable s still needs a full FILTER+1 edges.

Source files
------------

// File: rtl/sr_bank_pkg.sv
// Shared constants and types for the SR flop bank: S=R=1 policies, filter counter width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sr_bank_pkg;

  // Policy applied when a qualified S=R=1 pair is seen with en=1
  localparam int MODE_HOLD    = 0;
  localparam int MODE_SET_DOM = 1;
  localparam int MODE_RST_DOM = 2;
  localparam int MODE_TOGGLE  = 3;

  // Width of the per-channel stability counter
  localparam int CNT_W = 8;

  // {s,r} pair encoding, s in the MSB
  typedef enum logic [1:0] {
    PAIR_IDLE = 2'b00,
    PAIR_RST  = 2'b01,
    PAIR_SET  = 2'b10,
    PAIR_BOTH = 2'b11
  } pair_e;

endpackage

// File: rtl/sr_flop_bank_if.sv
// Bundle of the per-channel request and status vectors of the SR flop bank.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level/pulse status, no handshake.
//  master: drives en, s, r, clr_flags; observes q, qn, rise_flag, conflict, any_flag
//  slave : the bank itself, the mirror image of master
interface sr_flop_bank_if #(
  parameter int N = 8
);
  logic         en;
  logic [N-1:0] s;
  logic [N-1:0] r;
  logic [N-1:0] clr_flags;
  logic [N-1:0] q;
  logic [N-1:0] qn;
  logic [N-1:0] rise_flag;
  logic [N-1:0] conflict;
  logic         any_flag;

  modport master (
    output en, s, r, clr_flags,
    input  q, qn, rise_flag, conflict, any_flag
  );

  modport slave (
    input  en, s, r, clr_flags,
    output q, qn, rise_flag, conflict, any_flag
  );
endinterface

// File: rtl/sr_bank_chan.sv
// One SR storage channel: {s,r} stability filter, q register, conflict pulse, sticky rise flag.
// Latency: q updates FILTER+1 edges after {s,r} settles; rise_flag one edge after q rises.
// Backpressure: none; en gates q/conflict updates only, the filter always runs.
//  ports: clk, rst_n, en, s, r, clr_flag in; q, rise_flag, conflict out
module sr_bank_chan
  import sr_bank_pkg::*;
#(
  parameter int   FILTER    = 0,
  parameter int   MODE      = MODE_SET_DOM,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic clr_flag,
  output logic q,
  output logic rise_flag,
  output logic conflict
);

  localparam logic [CNT_W-1:0] FILT = CNT_W'(FILTER);

  logic [1:0]       pair;
  logic [1:0]       prev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             stable;
  logic             qual;
  logic             q_nxt;
  logic             q_d;

  assign pair   = {s, r};
  assign stable = (pair == prev);

  // Counter restarts on any change of the pair and saturates at FILTER.
  always_comb begin
    cnt_nxt = '0;
    if (stable) begin
      cnt_nxt = (cnt < FILT) ? cnt + 1'b1 : cnt;
    end
  end

  // Qualify on the edge at which the counter reaches FILTER, so the pair
  // acts on the (FILTER+1)-th edge it has been seen and every edge after.
  assign qual = (FILTER == 0) ? 1'b1 : (stable && (cnt_nxt == FILT));

  always_comb begin
    q_nxt = q;
    if (en && qual) begin
      case (pair)
        PAIR_SET: q_nxt = 1'b1;
        PAIR_RST: q_nxt = 1'b0;
        PAIR_BOTH: begin
          case (MODE)
            MODE_SET_DOM: q_nxt = 1'b1;
            MODE_RST_DOM: q_nxt = 1'b0;
            MODE_TOGGLE:  q_nxt = ~q;
            default:      q_nxt = q;
          endcase
        end
        default: q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= 2'b00;
      cnt       <= '0;
      q         <= RESET_VAL;
      q_d       <= RESET_VAL;  // matching q here keeps a reset value of 1 from looking like a rise
      conflict  <= 1'b0;
      rise_flag <= 1'b0;
    end else begin
      prev     <= pair;
      cnt      <= cnt_nxt;
      q        <= q_nxt;
      q_d      <= q;
      conflict <= en && qual && (pair == PAIR_BOTH);
      // a fresh rise beats a simultaneous clear
      if (q && !q_d) begin
        rise_flag <= 1'b1;
      end else if (clr_flag) begin
        rise_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sr_flop_bank.sv
// Bank of N independent clocked SR cells with shared enable, glitch filter and sticky rise flags.
// Latency: q FILTER+1 edges after {s,r} settles; rise_flag +1 edge; qn/any_flag combinational from regs.
// Backpressure: none; en is a plain update enable shared by all channels.
//  ports: clk, rst_n (async active-low); bus (slave): en, s, r, clr_flags in; q, qn, rise_flag, conflict, any_flag out
module sr_flop_bank
  import sr_bank_pkg::*;
#(
  parameter int           N         = 8,
  parameter int           FILTER    = 0,
  parameter int           MODE      = MODE_SET_DOM,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input logic           clk,
  input logic           rst_n,
  sr_flop_bank_if.slave bus
);

  if ((MODE < MODE_HOLD) || (MODE > MODE_TOGGLE) || (FILTER < 0) || (FILTER > 255) ||
      (N < 1) || (N > 32)) begin : g_param_check
    $fatal(1, "sr_flop_bank: illegal parameters N=%0d FILTER=%0d MODE=%0d", N, FILTER, MODE);
  end

  logic [N-1:0] q_w;
  logic [N-1:0] flag_w;
  logic [N-1:0] conflict_w;

  for (genvar i = 0; i < N; i++) begin : g_chan
    sr_bank_chan #(
      .FILTER    (FILTER),
      .MODE      (MODE),
      .RESET_VAL (RESET_VAL[i])
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (bus.en),
      .s         (bus.s[i]),
      .r         (bus.r[i]),
      .clr_flag  (bus.clr_flags[i]),
      .q         (q_w[i]),
      .rise_flag (flag_w[i]),
      .conflict  (conflict_w[i])
    );
  end

  assign bus.q         = q_w;
  assign bus.qn        = ~q_w;
  assign bus.rise_flag = flag_w;
  assign bus.conflict  = conflict_w;
  assign bus.any_flag  = |flag_w;

endmodule

// File: tb/tb_sr_flop_bank.sv
module tb_sr_flop_bank;

  localparam int N  = 4;
  localparam int ND = 5;  // dut0..3: FILTER=0 MODE=0..3; dut4: FILTER=3 MODE=3 RESET_VAL=1010

  typedef logic [16:0] vec_t;              // {q, qn, rise_flag, conflict, any_flag}
  typedef logic [ND-1:0][16:0] exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [N-1:0] s = '0;
  logic [N-1:0] r = '0;
  logic [N-1:0] clr = '0;

  vec_t act [ND];

  always #5 clk = ~clk;

  for (genvar k = 0; k < ND; k++) begin : g_dut
    localparam int           MD = (k < 4) ? k : 3;
    localparam int           FL = (k == 4) ? 3 : 0;
    localparam logic [N-1:0] RV = (k == 4) ? 4'b1010 : 4'b0000;
    sr_flop_bank_if #(.N(N)) bif ();
    assign bif.en        = en;
    assign bif.s         = s;
    assign bif.r         = r;
    assign bif.clr_flags = clr;
    sr_flop_bank #(.N(N), .FILTER(FL), .MODE(MD), .RESET_VAL(RV)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
    );
    assign act[k] = {bif.q, bif.qn, bif.rise_flag, bif.conflict, bif.any_flag};
  end

  // ---------------- reference model ----------------
  bit       mq    [ND][N];
  bit       mqd   [ND][N];   // q as it was one edge earlier, for rise detection
  bit       mflag [ND][N];
  bit       mconf [ND][N];
  bit [1:0] mlast [ND][N];
  int       mrun  [ND][N];   // number of consecutive edges the current pair has been seen

  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic int mode_of(int k);   return (k < 4) ? k : 3; endfunction
  function automatic int filt_of(int k);   return (k == 4) ? 3 : 0; endfunction
  function automatic bit rv_of(int k, int i);
    logic [N-1:0] v;
    v = (k == 4) ? 4'b1010 : 4'b0000;
    return v[i];
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < ND; k++)
      for (int i = 0; i < N; i++) begin
        mq[k][i] = rv_of(k, i); mqd[k][i] = rv_of(k, i);
        mflag[k][i] = 0; mconf[k][i] = 0; mlast[k][i] = 2'b00; mrun[k][i] = 0;
      end
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < ND; k++)
      for (int i = 0; i < N; i++) begin
        bit [1:0] p;
        bit       ok;
        bit       nq;
        p = {s[i], r[i]};
        if (p == mlast[k][i]) mrun[k][i] = (mrun[k][i] < 1000) ? mrun[k][i] + 1 : 1000;
        else begin mlast[k][i] = p; mrun[k][i] = 1; end
        ok = (filt_of(k) == 0) || (mrun[k][i] > filt_of(k));
        if (mq[k][i] && !mqd[k][i]) mflag[k][i] = 1;
        else if (clr[i]) mflag[k][i] = 0;
        nq = mq[k][i];
        if (en && ok) begin
          if (p == 2'b10) nq = 1;
          else if (p == 2'b01) nq = 0;
          else if (p == 2'b11) begin
            if (mode_of(k) == 1) nq = 1;
            else if (mode_of(k) == 2) nq = 0;
            else if (mode_of(k) == 3) nq = !mq[k][i];
          end
        end
        mconf[k][i] = en && ok && (p == 2'b11);
        mqd[k][i] = mq[k][i];
        mq[k][i] = nq;
      end
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    logic [N-1:0] qv, fv, cv;
    for (int k = 0; k < ND; k++) begin
      for (int i = 0; i < N; i++) begin
        qv[i] = mq[k][i]; fv[i] = mflag[k][i]; cv[i] = mconf[k][i];
      end
      e[k] = {qv, ~qv, fv, cv, |fv};
    end
    return e;
  endfunction

  function automatic void compare(string tag, int k, vec_t got, vec_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s dut%0d t=%0t got q=%b qn=%b flag=%b conf=%b any=%b want q=%b qn=%b flag=%b conf=%b any=%b",
                  tag, k, $time, got[16:13], got[12:9], got[8:5], got[4:1], got[0],
                  want[16:13], want[12:9], want[8:5], want[4:1], want[0]);
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        for (int k = 0; k < ND; k++) compare("sb", k, act[k], e[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Entered and left at posedge+2: drive inputs, push what the next edge must produce.
  task automatic step(input logic e, input logic [N-1:0] ss, input logic [N-1:0] rr,
                      input logic [N-1:0] cc);
    en = e; s = ss; r = rr; clr = cc;
    if (!rst_n) model_reset();
    else model_edge();
    sb_q.push_back(snapshot());
    @(posedge clk);
    #2;
  endtask

  // Drop reset between edges and check outputs without waiting for a clock.
  task automatic async_reset();
    exp_t e;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    e = snapshot();
    for (int k = 0; k < ND; k++) compare("async_rst", k, act[k], e[k]);
  endtask

  initial begin
    logic         re;
    logic [N-1:0] rs, rr, rc;
    int           hold;

    model_reset();
    repeat (3) step(0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;

    // set one channel, watch the flag follow
    step(1, 4'b0001, 4'h0, 4'h0);
    repeat (5) step(1, 4'h0, 4'h0, 4'h0);

    // S=R=1 under each policy, held long enough for the filtered DUT too
    repeat (6) step(1, 4'b0001, 4'b0001, 4'h0);
    repeat (2) step(1, 4'h0, 4'h0, 4'h0);

    // short pulse is swallowed by the filter, a long one is not
    repeat (2) step(1, 4'b0010, 4'h0, 4'h0);
    repeat (3) step(1, 4'h0, 4'h0, 4'h0);
    repeat (5) step(1, 4'b0010, 4'h0, 4'h0);

    // clear everything, then en=0 blocks updates
    repeat (5) step(1, 4'h0, 4'hF, 4'hF);
    repeat (10) step(0, 4'hF, 4'h0, 4'h0);
    repeat (2) step(1, 4'hF, 4'h0, 4'h0);

    // set beats clear in the same cycle, clear alone later drops the flag
    repeat (5) step(1, 4'h0, 4'hF, 4'hF);
    step(1, 4'b0100, 4'h0, 4'h0);
    step(1, 4'h0, 4'h0, 4'b0100);
    step(1, 4'h0, 4'h0, 4'h0);
    step(1, 4'h0, 4'h0, 4'hF);
    step(1, 4'h0, 4'h0, 4'h0);

    // reset in the middle of a filter qualification
    repeat (5) step(1, 4'h0, 4'hF, 4'hF);
    repeat (3) step(1, 4'b1000, 4'h0, 4'h0);
    async_reset();
    step(1, 4'b1000, 4'h0, 4'h0);
    rst_n = 1'b1;
    repeat (6) step(1, 4'b1000, 4'h0, 4'h0);

    // randomized traffic, pairs held a few cycles so the filter can qualify
    for (int n = 0; n < 80; n++) begin
      re = ($urandom_range(0, 3) != 0);
      rs = 4'($urandom());
      rr = 4'($urandom());
      hold = $urandom_range(1, 6);
      for (int h = 0; h < hold; h++) begin
        rc = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'h0;
        step(re, rs, rr, rc);
      end
      if ($urandom_range(0, 24) == 0) begin
        async_reset();
        step(re, rs, rr, 4'h0);
        rst_n = 1'b1;
      end
    end

    @(posedge clk);
    #3;
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL sb_drain left=%0d want 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
